prescaler_mch: RTL and testbench
================================

// Module: prescaler_mch
// PURPOSE
//  Parametrised multi-channel tick generator; successor to the fixed 40k terminal-count divider.
//  A base prescaler divides clk by BASE_DIV and emits a 1-clk base tick.
//  NCH independent channels divide that tick by a runtime-loaded divisor.
//  Each channel runs in periodic or one-shot mode; one-shot is used for debounce, scan and timeout timing.
// PARAMETERS
//  BASE_DIV  40000  base divide ratio, >=2
//  BASE_W    16     base counter width, 2**BASE_W >= BASE_DIV
//  NCH       4      number of channels, >=1
//  CNT_W     8      channel divisor/counter width
// PORTS
//  clk       input   1          system clock, all logic on posedge
//  rst       input   1          synchronous, active-high reset
//  en        input   1          base prescaler enable; 0 freezes base counter
//  base_tc   output  1          base tick, 1 clk wide
//  ch_load   input   NCH        per-channel load/start strobe
//  ch_div    input   NCH*CNT_W  per-channel divisor; channel i = [i*CNT_W +: CNT_W]
//  ch_mode   input   NCH        sampled on load: 0 periodic, 1 one-shot
//  ch_stop   input   NCH        per-channel stop strobe
//  ch_tc     output  NCH        channel terminal tick, 1 clk wide
//  ch_busy   output  NCH        channel in RUN
// BEHAVIOUR
//  Reset
//   - q <= BASE_DIV-1.
//   - All channels go to IDLE; cnt and div_r are cleared.
//   - base_tc, ch_tc and ch_busy are 0.
//  Base counter
//   - If en=1: q==0 reloads BASE_DIV-1; otherwise q decrements.
//   - If en=0: q holds.
//   - base_tc = en & (q==0), combinational from the registered q.
//   - First base_tc is on the BASE_DIV-th clk after rst deasserts with en=1; then every BASE_DIV clks.
//  Channel FSM, states IDLE and RUN
//   - Per-channel priority: rst > ch_stop > ch_load > base tick.
//   - ch_stop: go to IDLE, cnt unchanged, no ch_tc that cycle.
//   - ch_load with ch_div!=0: div_r <= ch_div, mode_r <= ch_mode, cnt <= ch_div-1, go to RUN.
//     Accepted in either state (restart). A base tick in the same cycle is not counted.
//   - ch_load with ch_div==0: go to IDLE (disable), no ch_tc.
//   - RUN & base_tc & cnt!=0: cnt <= cnt-1.
//   - RUN & base_tc & cnt==0: ch_tc=1 this cycle.
//     Periodic: cnt <= div_r-1, stay in RUN. One-shot: go to IDLE.
//   - ch_tc = RUN & base_tc & (cnt==0) & ~ch_stop & ~ch_load.
//     Combinational, cycle-aligned with base_tc.
//   - ch_busy = (state==RUN), registered.
//  Timing and widths
//   - Latency: the first ch_tc comes on the D-th base_tc after the load cycle.
//     Periodic spacing is then D*BASE_DIV clks.
//   - Divisor range is 1..2**CNT_W-1; div 1 gives ch_tc on every base tick.
//   - cnt and div_r are CNT_W bits; no wrap is possible because cnt==0 always reloads or idles.
//   - en=0 while channels are in RUN: channels freeze with the base counter.
//     No tick is lost or duplicated on resume.
//   - rst mid-operation: all outputs are 0 in the following cycle.
// STRUCTURE
//  Shared constants file
//   - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1.
//   - ST_IDLE=1'b0, ST_RUN=1'b1.
//  Sub-module tick_chan
//   - One channel: FSM, cnt, div_r, mode_r.
//   - Ports: clk, rst, tick, load, div, mode, stop, tc, busy.
//   - Instanced NCH times in a generate loop.
//  The base counter is inline in prescaler_mch.
// TESTING (BASE_DIV=4, BASE_W=3, NCH=2, CNT_W=4)
//  1. rst 2 clks, then en=1 -> base_tc on clks 4, 8, 12, ... after release; all ch_* = 0.
//  2. ch0 load div=3 periodic -> ch_tc[0] on base ticks 3, 6, 9 (every 12 clks); busy[0] stays 1.
//  3. ch1 load div=2 one-shot -> a single ch_tc[1] on the 2nd base tick.
//     busy[1] is 0 the next clk; no further ch_tc[1] over 10 ticks.
//  4. load div=0 -> busy=0, no ch_tc.
//     stop in the same cycle as a terminal base_tc -> ch_tc=0, busy=0.
//  5. load coincident with base_tc -> that tick is not counted; div=1 -> ch_tc on the next base_tc.
//  6. en=0 for 7 clks mid-period -> base_tc stays 0 and q holds; on resume, spacing continues exactly.
//     rst mid-RUN -> busy and tc are 0 next clk.

Source files
------------

// File: rtl/prescaler_mch_pkg.sv
// Shared constants and types for the multi-channel prescaler.
package prescaler_mch_pkg;

    // Channel run modes, sampled on load
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Channel FSM state encodings
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StRun  = ST_RUN
    } ch_state_e;

endpackage

// File: rtl/prescaler_mch_tick_chan.sv
// One prescaler channel: divides the shared base tick by a runtime-loaded divisor,
// in periodic or one-shot mode.
module prescaler_mch_tick_chan
    import prescaler_mch_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    input  logic             mode,
    input  logic             stop,
    output logic             tc,
    output logic             busy
);

    ch_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             mode_q;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Terminal tick is suppressed whenever stop or load takes priority this cycle
    assign tc   = (state_q == StRun) & tick & cnt_zero & ~stop & ~load;
    assign busy = (state_q == StRun);

    // Channel FSM: priority rst > stop > load > base tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            div_q   <= '0;
            mode_q  <= MODE_PERIODIC;
        end else if (stop) begin
            state_q <= StIdle;
        end else if (load) begin
            if (div != '0) begin
                div_q   <= div;
                mode_q  <= mode;
                cnt_q   <= div - CNT_W'(1);
                state_q <= StRun;
            end else begin
                // A zero divisor disables the channel
                state_q <= StIdle;
            end
        end else if (state_q == StRun && tick) begin
            if (!cnt_zero) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else if (mode_q == MODE_ONESHOT) begin
                state_q <= StIdle;
            end else begin
                cnt_q <= div_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prescaler_mch.sv
// Multi-channel tick generator: a base prescaler divides clk by BASE_DIV and
// NCH independent channels divide the resulting base tick further.
module prescaler_mch
    import prescaler_mch_pkg::*;
#(
    parameter int unsigned BASE_DIV = 40000,
    parameter int unsigned BASE_W   = 16,
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               base_tc,
    input  logic [NCH-1:0]     ch_load,
    input  logic [NCH*CNT_W-1:0] ch_div,
    input  logic [NCH-1:0]     ch_mode,
    input  logic [NCH-1:0]     ch_stop,
    output logic [NCH-1:0]     ch_tc,
    output logic [NCH-1:0]     ch_busy
);

    localparam logic [BASE_W-1:0] BaseReload = BASE_W'(BASE_DIV - 1);

    logic [BASE_W-1:0] q;

    // Base down-counter; en=0 freezes it so channels pause without losing a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BaseReload;
        end else if (en) begin
            if (q == '0) begin
                q <= BaseReload;
            end else begin
                q <= q - BASE_W'(1);
            end
        end
    end

    assign base_tc = en & (q == '0);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        prescaler_mch_tick_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .tick (base_tc),
            .load (ch_load[i]),
            .div  (ch_div[i*CNT_W +: CNT_W]),
            .mode (ch_mode[i]),
            .stop (ch_stop[i]),
            .tc   (ch_tc[i]),
            .busy (ch_busy[i])
        );
    end

endmodule

// File: tb/tb_prescaler_mch.sv
// Scoreboard bench for prescaler_mch with BASE_DIV=4, NCH=2, CNT_W=4.
// Cycle c is the interval after the c-th posedge; expected pulse cycles are
// queued by the stimulus and consumed by the monitor when a pulse appears.
module tb_prescaler_mch;

    localparam int unsigned BASE_DIV = 4;
    localparam int unsigned BASE_W   = 3;
    localparam int unsigned NCH      = 2;
    localparam int unsigned CNT_W    = 4;

    logic               clk;
    logic               rst;
    logic               en;
    logic               base_tc;
    logic [NCH-1:0]     ch_load;
    logic [NCH*CNT_W-1:0] ch_div;
    logic [NCH-1:0]     ch_mode;
    logic [NCH-1:0]     ch_stop;
    logic [NCH-1:0]     ch_tc;
    logic [NCH-1:0]     ch_busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // Expected pulse cycles: 0 = base_tc, 1 = ch_tc[0], 2 = ch_tc[1]
    int exp_q [3][$];

    prescaler_mch #(
        .BASE_DIV(BASE_DIV),
        .BASE_W  (BASE_W),
        .NCH     (NCH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .base_tc(base_tc),
        .ch_load(ch_load),
        .ch_div (ch_div),
        .ch_mode(ch_mode),
        .ch_stop(ch_stop),
        .ch_tc  (ch_tc),
        .ch_busy(ch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_evt(input int s, input string nm, input logic pulse);
        int e;
        // Any expected pulse whose cycle has passed was missed
        while (exp_q[s].size() > 0 && exp_q[s][0] < cyc) begin
            e = exp_q[s].pop_front();
            checks++;
            failures++;
            $display("FAIL %s missing pulse: expected at cycle %0d, no pulse observed", nm, e);
        end
        if (pulse !== 1'b0) begin
            checks++;
            if (exp_q[s].size() == 0) begin
                failures++;
                $display("FAIL %s unexpected pulse at cycle %0d, expected none", nm, cyc);
            end else begin
                e = exp_q[s].pop_front();
                if (e != cyc) begin
                    failures++;
                    $display("FAIL %s pulse at cycle %0d, expected at cycle %0d", nm, cyc, e);
                end
            end
        end
    endtask

    // Monitor: compares every output pulse against the scoreboard
    always @(negedge clk) begin
        if (cyc >= 2) begin
            check_evt(0, "base_tc", base_tc);
            check_evt(1, "ch_tc0", ch_tc[0]);
            check_evt(2, "ch_tc1", ch_tc[1]);
        end
    end

    task automatic drive_load(input int ch, input logic [CNT_W-1:0] d, input logic m);
        ch_load[ch]               = 1'b1;
        ch_div[ch*CNT_W +: CNT_W] = d;
        ch_mode[ch]               = m;
    endtask

    initial begin
        #20000;
        failures++;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        ch_load = '0;
        ch_div  = '0;
        ch_mode = '0;
        ch_stop = '0;

        // 1. Reset for two clocks, then base ticks every 4 clocks
        goto(2);
        chk("reset base_tc", 32'(base_tc), 32'd0);
        chk("reset ch_busy", 32'(ch_busy), 32'd0);
        chk("reset ch_tc", 32'(ch_tc), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 15; k++) exp_q[0].push_back(1 + 4 * k);  // 5 .. 61

        // 2. ch0 periodic div=3; stopped later at its third terminal tick
        goto(14);
        drive_load(0, 4'd3, 1'b0);
        exp_q[1].push_back(25);
        exp_q[1].push_back(37);
        goto(15);
        ch_load = '0;
        chk("ch0 busy after load", 32'(ch_busy[0]), 32'd1);
        goto(16);
        chk("ch1 idle", 32'(ch_busy[1]), 32'd0);

        // 3. ch1 one-shot div=2
        goto(26);
        drive_load(1, 4'd2, 1'b1);
        exp_q[2].push_back(33);
        goto(27);
        ch_load = '0;
        chk("ch1 busy after load", 32'(ch_busy[1]), 32'd1);
        goto(34);
        chk("ch1 idle after one-shot", 32'(ch_busy[1]), 32'd0);
        goto(45);
        chk("ch0 still busy", 32'(ch_busy[0]), 32'd1);

        // 4a. Stop coincident with ch0 terminal tick
        goto(49);
        ch_stop[0] = 1'b1;
        goto(50);
        ch_stop = '0;
        chk("ch0 idle after stop", 32'(ch_busy[0]), 32'd0);

        // 5. Loads coincident with a base tick: that tick is not counted
        goto(53);
        drive_load(0, 4'd1, 1'b0);
        drive_load(1, 4'd2, 1'b1);
        exp_q[1].push_back(57);
        exp_q[1].push_back(61);
        exp_q[1].push_back(72);
        exp_q[1].push_back(76);
        exp_q[1].push_back(80);
        exp_q[2].push_back(61);
        goto(54);
        ch_load = '0;
        chk("ch0 busy after restart", 32'(ch_busy[0]), 32'd1);
        chk("ch1 busy after restart", 32'(ch_busy[1]), 32'd1);
        goto(62);
        chk("ch1 idle after second one-shot", 32'(ch_busy[1]), 32'd0);

        // 6a. en=0 for 7 clocks while q sits at its terminal value
        goto(65);
        en = 1'b0;
        exp_q[0].push_back(72);
        exp_q[0].push_back(76);
        exp_q[0].push_back(80);
        goto(68);
        chk("ch0 busy while paused", 32'(ch_busy[0]), 32'd1);
        goto(72);
        en = 1'b1;

        // 6b. Reset mid-run
        goto(82);
        rst = 1'b1;
        exp_q[0].push_back(86);
        exp_q[0].push_back(90);
        exp_q[0].push_back(94);
        exp_q[0].push_back(98);
        goto(83);
        rst = 1'b0;
        chk("busy after mid-run reset", 32'(ch_busy), 32'd0);
        chk("ch_tc after mid-run reset", 32'(ch_tc), 32'd0);
        chk("base_tc after mid-run reset", 32'(base_tc), 32'd0);

        // 4b. Load with div=0 disables a running channel
        goto(84);
        drive_load(1, 4'd5, 1'b0);
        goto(85);
        ch_load = '0;
        chk("ch1 busy div5", 32'(ch_busy[1]), 32'd1);
        chk("ch0 idle after reset", 32'(ch_busy[0]), 32'd0);
        goto(88);
        drive_load(1, 4'd0, 1'b0);
        goto(89);
        ch_load = '0;
        chk("ch1 idle after div0 load", 32'(ch_busy[1]), 32'd0);

        goto(100);
        @(negedge clk);
        #1;
        chk("base_tc queue drained", 32'(exp_q[0].size()), 32'd0);
        chk("ch_tc0 queue drained", 32'(exp_q[1].size()), 32'd0);
        chk("ch_tc1 queue drained", 32'(exp_q[2].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
